// File: rtl/uart_parser_pkg.sv
// Shared state encoding and defaults for the UART host-command frame parser.
package uart_parser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        PAYLOAD,
        CSUM,
        HOLD
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         DEFAULT_MAX_LEN   = 64;
    localparam int         STAT_W            = 16;

endpackage

// File: rtl/frame_payload_ram.sv
// Simple dual-port payload buffer: synchronous write, registered read (1-cycle latency).
module frame_payload_ram
    import uart_parser_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_MAX_LEN,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset so the array still maps onto RAM primitives.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts SYNC/CMD/LEN/payload/CSUM frames from the receiver byte stream and holds them for a consumer.
// Optional statistics counters are built when UART_PARSER_STATS_EN is defined.
module uart_frame_parser
    import uart_parser_pkg::*;
#(
    parameter int          MAX_LEN   = DEFAULT_MAX_LEN,
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
    localparam int         ADDR_W    = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_ready,
    input  logic              rx_endofpacket,
    output logic              frame_valid,
    output logic [7:0]        frame_cmd,
    output logic [ADDR_W:0]   frame_len,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              err_csum,
    output logic              err_len,
    output logic              err_abort,
    output logic              err_overrun,
    output logic [STAT_W-1:0] stat_frames,
    output logic [STAT_W-1:0] stat_errors
);

    localparam int         LEN_W     = ADDR_W + 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t            state, state_next;
    logic [7:0]        sum;
    logic [ADDR_W-1:0] wr_ptr;
    logic              take, ram_we, last_byte, sum_ok;
    logic              csum_bad, len_bad, abort, overrun;

    // End-of-packet outranks a same-cycle byte, so it is masked out of byte consumption.
    assign take      = rx_data_ready && !rx_endofpacket;
    assign last_byte = (LEN_W'(wr_ptr) + LEN_W'(1)) == frame_len;
    assign sum_ok    = (sum + rx_data) == '0;
    assign frame_valid = (state == HOLD);

    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        csum_bad   = 1'b0;
        len_bad    = 1'b0;
        abort      = 1'b0;
        overrun    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_data_ready && rx_data == SYNC_BYTE) state_next = CMD;
            end
            HOLD: begin
                overrun = rx_data_ready;
                if (frame_ack) state_next = IDLE;
            end
            default: begin
                if (rx_endofpacket) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else if (take) begin
                    case (state)
                        CMD: state_next = LEN;
                        LEN: begin
                            if (rx_data > MAX_LEN_B) begin
                                len_bad    = 1'b1;
                                state_next = IDLE;
                            end else if (rx_data == 8'h00) begin
                                state_next = CSUM;
                            end else begin
                                state_next = PAYLOAD;
                            end
                        end
                        PAYLOAD: begin
                            ram_we = 1'b1;
                            if (last_byte) state_next = CSUM;
                        end
                        CSUM: begin
                            if (sum_ok) begin
                                state_next = HOLD;
                            end else begin
                                csum_bad   = 1'b1;
                                state_next = IDLE;
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sum         <= '0;
            wr_ptr      <= '0;
            frame_cmd   <= '0;
            frame_len   <= '0;
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_abort   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_next;
            err_csum    <= csum_bad;
            err_len     <= len_bad;
            err_abort   <= abort;
            err_overrun <= overrun;
            if (take) begin
                case (state)
                    CMD: begin
                        frame_cmd <= rx_data;
                        sum       <= rx_data;
                    end
                    LEN: begin
                        sum    <= sum + rx_data;
                        wr_ptr <= '0;
                        if (rx_data <= MAX_LEN_B) frame_len <= LEN_W'(rx_data);
                    end
                    PAYLOAD: begin
                        sum    <= sum + rx_data;
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    frame_payload_ram #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

`ifdef UART_PARSER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames <= '0;
            stat_errors <= '0;
        end else begin
            if (state != HOLD && state_next == HOLD && stat_frames != '1)
                stat_frames <= stat_frames + STAT_W'(1);
            if ((err_csum || err_len || err_abort || err_overrun) && stat_errors != '1)
                stat_errors <= stat_errors + STAT_W'(1);
        end
    end
`else
    assign stat_frames = '0;
    assign stat_errors = '0;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: expected frame/error events are queued as bytes are driven.
module tb_uart_frame_parser;

    localparam int MAXL = 64;
    localparam int AW   = $clog2(MAXL);

    localparam int K_FRAME = 0;
    localparam int K_CSUM  = 1;
    localparam int K_LEN   = 2;
    localparam int K_ABORT = 3;
    localparam int K_OVR   = 4;

    typedef struct {
        int         kind;
        logic [7:0] cmd;
        logic [7:0] len;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_data_ready;
    logic          rx_endofpacket;
    logic          frame_valid;
    logic [7:0]    frame_cmd;
    logic [AW:0]   frame_len;
    logic          frame_ack;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          err_csum, err_len, err_abort, err_overrun;
    logic [15:0]   stat_frames, stat_errors;

    ev_t        sb[$];
    int         errors = 0;
    int         checks = 0;
    int         exp_frames = 0;
    int         exp_errs = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] pay [MAXL];

    always #5 clk = ~clk;

    uart_frame_parser #(
        .MAX_LEN   (MAXL),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_data_ready  (rx_data_ready),
        .rx_endofpacket (rx_endofpacket),
        .frame_valid    (frame_valid),
        .frame_cmd      (frame_cmd),
        .frame_len      (frame_len),
        .frame_ack      (frame_ack),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .err_csum       (err_csum),
        .err_len        (err_len),
        .err_abort      (err_abort),
        .err_overrun    (err_overrun),
        .stat_frames    (stat_frames),
        .stat_errors    (stat_errors)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [7:0] cmd, input logic [7:0] len);
        ev_t e;
        e.kind = kind;
        e.cmd  = cmd;
        e.len  = len;
        sb.push_back(e);
        if (kind == K_FRAME) exp_frames++;
        else exp_errs++;
    endtask

    task automatic observe(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            check("unexpected_event", kind, 32'hFF);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == K_FRAME) begin
                check("event_cmd", frame_cmd, e.cmd);
                check("event_len", frame_len, e.len);
            end
        end
    endtask

    // Output monitor: every error pulse cycle and every frame_valid rise consumes one queued event.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (frame_valid && !prev_valid) observe(K_FRAME);
            if (err_csum)    observe(K_CSUM);
            if (err_len)     observe(K_LEN);
            if (err_abort)   observe(K_ABORT);
            if (err_overrun) observe(K_OVR);
            prev_valid = frame_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data       = b;
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
    endtask

    task automatic send_eop();
        @(posedge clk); #1;
        rx_endofpacket = 1'b1;
        @(posedge clk); #1;
        rx_endofpacket = 1'b0;
    endtask

    // Good frame from pay[]; checksum accumulated from cmd, len and payload as bytes are sent.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len);
        logic [7:0] s;
        s = cmd + len;
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(len);
        for (int i = 0; i < int'(len); i++) begin
            s = s + pay[i];
            send_byte(pay[i]);
        end
        push_ev(K_FRAME, cmd, len);
        send_byte(8'h00 - s);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !frame_valid; i++) @(negedge clk);
        check(tag, frame_valid, 1);
    endtask

    task automatic read_check(input string tag, input int addr, input logic [7:0] exp);
        @(posedge clk); #1;
        rd_addr = AW'(addr);
        @(posedge clk);
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    task automatic ack_frame(input string tag);
        @(posedge clk); #1;
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
        @(negedge clk);
        check(tag, frame_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, frame_valid, 0);
        check({tag, "_cmd"}, frame_cmd, 0);
        check({tag, "_len"}, frame_len, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_errs"}, {err_csum, err_len, err_abort, err_overrun}, 0);
        check({tag, "_stat_frames"}, stat_frames, 0);
        check({tag, "_stat_errors"}, stat_errors, 0);
    endtask

    initial begin
        rst = 1'b1;
        rx_data = '0;
        rx_data_ready = 1'b0;
        rx_endofpacket = 1'b0;
        frame_ack = 1'b0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Noise before SYNC is ignored, then a 3-byte frame.
        send_byte(8'h00);
        send_byte(8'h33);
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(8'h10, 8'd3);
        wait_valid("a_valid");
        check("a_cmd", frame_cmd, 8'h10);
        check("a_len", frame_len, 3);
        for (int i = 0; i < 3; i++) read_check("a_payload", i, pay[i]);
        ack_frame("a_ack");

        // Bad checksum: 10+01+FF = 10, CSUM 00.
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h01);
        send_byte(8'hFF);
        push_ev(K_CSUM, 8'h00, 8'h00);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        check("csum_no_valid", frame_valid, 0);

        // Zero-length frame A5 20 00 E0.
        send_frame(8'h20, 8'd0);
        wait_valid("z_valid");
        check("z_len", frame_len, 0);
        ack_frame("z_ack");

        // LEN = MAX_LEN+1, trailing bytes ignored.
        send_byte(8'hA5);
        send_byte(8'h50);
        push_ev(K_LEN, 8'h00, 8'h00);
        send_byte(8'(MAXL + 1));
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        repeat (3) @(negedge clk);
        check("len_no_valid", frame_valid, 0);

        // Abort mid-payload.
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h03);
        send_byte(8'h11);
        push_ev(K_ABORT, 8'h00, 8'h00);
        send_eop();
        repeat (3) @(negedge clk);
        check("abort_no_valid", frame_valid, 0);

        // Held frame with two overrun bytes (second is a SYNC that must not restart parsing).
        pay[0] = 8'hAA; pay[1] = 8'hBB;
        send_frame(8'h30, 8'd2);
        wait_valid("o_valid");
        push_ev(K_OVR, 8'h00, 8'h00);
        send_byte(8'h5A);
        push_ev(K_OVR, 8'h00, 8'h00);
        send_byte(8'hA5);
        @(negedge clk);
        check("o_still_valid", frame_valid, 1);
        check("o_cmd", frame_cmd, 8'h30);
        check("o_len", frame_len, 2);
        read_check("o_payload0", 0, 8'hAA);
        read_check("o_payload1", 1, 8'hBB);
        ack_frame("o_ack");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
`ifdef UART_PARSER_STATS_EN
        check("stat_frames", stat_frames, exp_frames);
        check("stat_errors", stat_errors, exp_errs);
`else
        check("stat_frames_off", stat_frames, 0);
        check("stat_errors_off", stat_errors, 0);
`endif

        // Reset in the middle of a payload.
        send_byte(8'hA5);
        send_byte(8'h40);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");

        // Recovery after reset.
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        send_frame(8'h40, 8'd4);
        wait_valid("r_valid");
        for (int i = 0; i < 4; i++) read_check("r_payload", i, pay[i]);
        ack_frame("r_ack");
        repeat (3) @(negedge clk);
        check("final_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
